// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared command codes, reply codes and sequencer states
package aes_uart_pkg;

    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_ENC   = 8'h45;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NOKEY = 8'hEE;
    localparam int         BLK_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_KEY,
        ST_RX_PT,
        ST_AES_RUN,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_e;

endpackage

// File: rtl/aes_uart_timeout.sv
// rtl/aes_uart_timeout.sv - inter-byte idle counter with one-cycle expiry flag
module aes_uart_timeout #(
    parameter int TIMEOUT_CYC = 520833,
    parameter int CNT_W       = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    // Idle count: restarts on clear, saturates at the limit while enabled
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry does not look at clear so the sequencer can depend on it without a loop
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/aes_uart_ctrl.sv
// rtl/aes_uart_ctrl.sv - UART command sequencer feeding the AES core
module aes_uart_ctrl
    import aes_uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 520833,
    parameter int CNT_W       = 20
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_done,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         key_valid,
    output logic         busy
);

    state_e         state_q, state_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    // Only 15 earlier bytes need holding; the 16th is taken straight from rx_byte
    logic [119:0]   rx_sr_q, rx_sr_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   din_q, din_d;
    logic           key_valid_q, key_valid_d;
    logic [127:0]   tx_buf_q, tx_buf_d;
    logic [4:0]     tx_rem_q, tx_rem_d;
    logic           tx_start_q, aes_start_q;
    logic [127:0]   blk_word;
    logic           tmo_clear, tmo_enable, tmo_expired;

    assign blk_word   = {rx_sr_q, rx_byte};
    assign tmo_enable = (state_q == ST_RX_KEY) || (state_q == ST_RX_PT);
    assign tmo_clear  = rx_valid || (state_d != state_q);

    aes_uart_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (tmo_clear),
        .enable    (tmo_enable),
        .expired   (tmo_expired)
    );

    // Next-state: command decode, block assembly, AES launch and reply streaming
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        rx_sr_d     = rx_sr_q;
        key_d       = key_q;
        din_d       = din_q;
        key_valid_d = key_valid_q;
        tx_buf_d    = tx_buf_q;
        tx_rem_d    = tx_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == CMD_KEY) begin
                        state_d    = ST_RX_KEY;
                        byte_cnt_d = '0;
                    end else if (rx_byte == CMD_ENC) begin
                        if (key_valid_q) begin
                            state_d    = ST_RX_PT;
                            byte_cnt_d = '0;
                        end else begin
                            tx_buf_d = {RSP_NOKEY, 120'd0};
                            tx_rem_d = 5'd1;
                            state_d  = ST_TX_LOAD;
                        end
                    end
                end
            end
            ST_RX_KEY, ST_RX_PT: begin
                if (rx_valid) begin
                    rx_sr_d    = blk_word[119:0];
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'(BLK_BYTES - 1)) begin
                        if (state_q == ST_RX_KEY) begin
                            key_d       = blk_word;
                            key_valid_d = 1'b1;
                            tx_buf_d    = {RSP_ACK, 120'd0};
                            tx_rem_d    = 5'd1;
                            state_d     = ST_TX_LOAD;
                        end else begin
                            din_d   = blk_word;
                            state_d = ST_AES_RUN;
                        end
                    end
                end else if (tmo_expired) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                end
            end
            ST_AES_RUN: begin
                if (aes_done) begin
                    tx_buf_d = aes_dout;
                    tx_rem_d = 5'(BLK_BYTES);
                    state_d  = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    tx_buf_d = {tx_buf_q[119:0], 8'h00};
                    tx_rem_d = tx_rem_q - 5'd1;
                    state_d  = (tx_rem_q == 5'd1) ? ST_IDLE : ST_TX_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes are registered so they are glitch-free
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            rx_sr_q     <= '0;
            key_q       <= '0;
            din_q       <= '0;
            key_valid_q <= 1'b0;
            tx_buf_q    <= '0;
            tx_rem_q    <= '0;
            tx_start_q  <= 1'b0;
            aes_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_sr_q     <= rx_sr_d;
            key_q       <= key_d;
            din_q       <= din_d;
            key_valid_q <= key_valid_d;
            tx_buf_q    <= tx_buf_d;
            tx_rem_q    <= tx_rem_d;
            tx_start_q  <= (state_q == ST_TX_LOAD);
            aes_start_q <= (state_d == ST_AES_RUN) && (state_q != ST_AES_RUN);
        end
    end

    assign tx_data   = tx_buf_q[127:120];
    assign tx_start  = tx_start_q;
    assign aes_key   = key_q;
    assign aes_din   = din_q;
    assign aes_start = aes_start_q;
    assign key_valid = key_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// tb/tb_aes_uart_ctrl.sv - self-checking bench for aes_uart_ctrl
module tb_aes_uart_ctrl;

    localparam int TMO = 100;
    localparam logic [127:0] CIPHER = {8{16'hAA55}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_done;
    logic [127:0] aes_key, aes_din, aes_dout;
    logic         aes_start, aes_done, key_valid, busy;

    aes_uart_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(20)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .aes_key   (aes_key),
        .aes_din   (aes_din),
        .aes_start (aes_start),
        .aes_done  (aes_done),
        .aes_dout  (aes_dout),
        .key_valid (key_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 key bytes, 2 plaintext bytes, 3 AES, 4 replying
    int       m_mode = 0;
    bit       m_on = 0;
    logic [7:0] m_bytes[$];
    logic [7:0] m_reply[$];
    logic [127:0] m_key = '0, m_din = '0;
    bit       m_kv = 0, m_sent = 0, m_txs = 0, m_as = 0;
    int       m_idle = 0;

    function automatic logic [127:0] pack16();
        logic [127:0] w = '0;
        for (int i = 0; i < 16; i++) w = {w[119:0], m_bytes[i]};
        return w;
    endfunction

    always @(posedge clk) begin
        m_txs = 0;
        m_as  = 0;
        if (!rst_n) begin
            m_on = 1; m_mode = 0; m_key = '0; m_din = '0; m_kv = 0;
            m_bytes.delete(); m_reply.delete(); m_sent = 0; m_idle = 0;
        end else begin
            case (m_mode)
                0: if (rx_valid) begin
                    m_bytes.delete(); m_idle = 0;
                    if (rx_byte == 8'h4B) m_mode = 1;
                    else if (rx_byte == 8'h45) begin
                        if (m_kv) m_mode = 2;
                        else begin m_reply = {8'hEE}; m_sent = 0; m_mode = 4; end
                    end
                end
                1, 2: if (rx_valid) begin
                    m_bytes.push_back(rx_byte); m_idle = 0;
                    if (m_bytes.size() == 16) begin
                        if (m_mode == 1) begin
                            m_key = pack16(); m_kv = 1;
                            m_reply = {8'h06}; m_sent = 0; m_mode = 4;
                        end else begin
                            m_din = pack16(); m_as = 1; m_mode = 3;
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TMO) m_mode = 0;
                end
                3: if (aes_done) begin
                    m_reply.delete();
                    for (int i = 15; i >= 0; i--) m_reply.push_back(aes_dout[i*8 +: 8]);
                    m_sent = 0; m_mode = 4;
                end
                default: if (!m_sent) begin
                    m_txs = 1; m_sent = 1;
                end else if (tx_done) begin
                    void'(m_reply.pop_front());
                    m_sent = 0;
                    if (m_reply.size() == 0) m_mode = 0;
                end
            endcase
        end
    end

    // Compare every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", {127'd0, busy}, {127'd0, m_mode != 0});
            chk("key_valid", {127'd0, key_valid}, {127'd0, m_kv});
            chk("aes_key", aes_key, m_key);
            chk("aes_din", aes_din, m_din);
            chk("tx_start", {127'd0, tx_start}, {127'd0, m_txs});
            chk("aes_start", {127'd0, aes_start}, {127'd0, m_as});
            if (m_mode == 4) chk("tx_data", {120'd0, tx_data}, {120'd0, m_reply[0]});
        end
    end

    // Captured reply bytes, start pulses, and tx_start latency from the triggering event
    logic [7:0] cap[$];
    int n_as = 0;
    int last_evt = -100;
    always @(negedge clk) begin
        if (tx_start) begin
            cap.push_back(tx_data);
            chk("tx_start_lat", 128'(cyc - last_evt), 128'd2);
        end
        if (aes_start) n_as++;
        if (rx_valid || tx_done || aes_done) last_evt = cyc;
    end

    // UART transmitter stand-in
    initial begin
        tx_done = 0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1;
                @(posedge clk);
                #1 tx_done = 0;
            end
        end
    end

    // AES core stand-in: ciphertext 20 cycles after start, or a stray done on request
    int spur_req = 0;
    int spur_seen = 0;
    initial begin
        aes_done = 0;
        aes_dout = '0;
        forever begin
            @(negedge clk);
            if (aes_start) begin
                repeat (20) @(posedge clk);
                #1 aes_done = 1; aes_dout = CIPHER;
                @(posedge clk);
                #1 aes_done = 0;
            end else if (spur_seen != spur_req) begin
                spur_seen = spur_req;
                @(posedge clk);
                #1 aes_done = 1; aes_dout = 128'hDEADBEEF_00000000_11111111_22222222;
                @(posedge clk);
                #1 aes_done = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1;
        step(1);
        rx_valid = 0;
        step(gap);
    endtask

    task automatic wait_idle(input string name, input int max);
        int i;
        for (i = 0; i < max && busy; i++) step(1);
        if (i >= max) chk({name, "_idle_timeout"}, {127'd0, busy}, 128'd0);
    endtask

    task automatic wait_cap(input int n, input int max);
        int i;
        for (i = 0; i < max && cap.size() < n; i++) step(1);
        if (i >= max) chk("cap_timeout", 128'(cap.size()), 128'(n));
    endtask

    logic [127:0] key0 = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] pt0  = 128'h101112131415161718191A1B1C1D1E1F;

    initial begin
        rst_n = 0; rx_valid = 0; rx_byte = 8'h00;
        step(3);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_txs", {127'd0, tx_start}, 128'd0);
        chk("rst_key", aes_key, 128'd0);
        chk("rst_kv", {127'd0, key_valid}, 128'd0);
        rst_n = 1;
        step(2);

        // 'E' with no key: single 0xEE reply, AES untouched
        cap.delete(); n_as = 0;
        send(8'h45, 0);
        chk("nokey_busy", {127'd0, busy}, 128'd1);
        wait_idle("nokey", 200);
        chk("nokey_len", 128'(cap.size()), 128'd1);
        if (cap.size() > 0) chk("nokey_byte", {120'd0, cap[0]}, 128'hEE);
        chk("nokey_as", 128'(n_as), 128'd0);
        chk("nokey_idle", {127'd0, busy}, 128'd0);

        // Ignored junk byte, then key load with 50-cycle gaps
        send(8'h99, 3);
        chk("junk_busy", {127'd0, busy}, 128'd0);
        cap.delete();
        send(8'h4B, 50);
        for (int i = 0; i < 16; i++) send(8'(i), 50);
        wait_idle("key", 200);
        chk("key_val", aes_key, key0);
        chk("key_kv", {127'd0, key_valid}, 128'd1);
        chk("key_len", 128'(cap.size()), 128'd1);
        if (cap.size() > 0) chk("key_ack", {120'd0, cap[0]}, 128'h06);

        // Encrypt one block, inject a stray 'K' while AES runs
        cap.delete(); n_as = 0;
        send(8'h45, 2);
        for (int i = 0; i < 15; i++) send(8'(8'h10 + i), 2);
        send(8'h1F, 0);
        chk("enc_as_now", {127'd0, aes_start}, 128'd1);
        chk("enc_din", aes_din, pt0);
        step(1);
        chk("enc_as_once", {127'd0, aes_start}, 128'd0);
        step(2);
        send(8'h4B, 0);
        wait_idle("enc", 500);
        chk("enc_as_cnt", 128'(n_as), 128'd1);
        chk("enc_len", 128'(cap.size()), 128'd16);
        for (int i = 0; i < 16 && i < cap.size(); i++)
            chk("enc_byte", {120'd0, cap[i]}, (i % 2 == 0) ? 128'hAA : 128'h55);
        chk("enc_key_kept", aes_key, key0);

        // Stray aes_done while idle
        spur_req++;
        step(5);
        chk("spur_busy", {127'd0, busy}, 128'd0);
        chk("spur_din", aes_din, pt0);

        // Partial key then silence: timeout after exactly TMO cycles
        send(8'h4B, 2);
        for (int i = 0; i < 4; i++) send(8'hF0, 2);
        send(8'hF0, 0);
        step(TMO - 1);
        chk("tmo_still_busy", {127'd0, busy}, 128'd1);
        step(1);
        chk("tmo_idle", {127'd0, busy}, 128'd0);
        chk("tmo_key", aes_key, key0);
        chk("tmo_kv", {127'd0, key_valid}, 128'd1);
        send(8'h45, 0);
        chk("tmo_enc_accepted", {127'd0, busy}, 128'd1);
        step(TMO + 2);
        chk("tmo2_idle", {127'd0, busy}, 128'd0);

        // Reset while ciphertext is streaming
        cap.delete();
        send(8'h45, 1);
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1);
        wait_cap(3, 500);
        rst_n = 0;
        step(1);
        rst_n = 1;
        chk("mrst_busy", {127'd0, busy}, 128'd0);
        chk("mrst_kv", {127'd0, key_valid}, 128'd0);
        chk("mrst_key", aes_key, 128'd0);
        chk("mrst_din", aes_din, 128'd0);
        chk("mrst_txs", {127'd0, tx_start}, 128'd0);
        chk("mrst_txd", {120'd0, tx_data}, 128'd0);
        chk("mrst_as", {127'd0, aes_start}, 128'd0);
        step(20);
        chk("mrst_quiet", {127'd0, busy}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_uart_ctrl.md
# aes_uart_ctrl

Command sequencer between the UART byte receiver/transmitter and the AES core. It parses single-byte commands from the serial link, assembles 128-bit key and plaintext blocks from 16 received bytes, and launches the AES core. It streams the 16-byte ciphertext (or a status byte) back through the UART transmitter. It is the only block that drives the AES core's control inputs.

## Interface
- `TIMEOUT_CYC`, 520833: inter-byte idle limit in clocks, about 10 byte times at 9600 Bd / 50 MHz. Minimum 2.
- `CNT_W`, 20: width of the timeout counter. Must satisfy `2^CNT_W > TIMEOUT_CYC`.
- `sys_clk` in 1: system clock. The block uses this single clock.
- `sys_rst_n` in 1: reset, synchronous and active-low.
- `rx_byte` in 8: received byte. Valid only when `rx_valid` is high.
- `rx_valid` in 1: one-cycle strobe from the UART receiver.
- `tx_data` out 8: byte to send. Held stable from `tx_start` until `tx_done`.
- `tx_start` out 1: one-cycle request to the UART transmitter.
- `tx_done` in 1: one-cycle pulse from the transmitter at the end of the stop bit.
- `aes_key` out 128: committed key.
- `aes_din` out 128: plaintext block.
- `aes_start` out 1: one-cycle start pulse to the AES core.
- `aes_done` in 1: one-cycle pulse; `aes_dout` is valid in that cycle.
- `aes_dout` in 128: ciphertext.
- `key_valid` out 1: a key has been committed since reset.
- `busy` out 1: high in every state except IDLE.

## Operation
- Command bytes: `0x4B` ('K') loads a key; `0x45` ('E') encrypts one block. All other bytes received in IDLE are ignored.
- Reply bytes: `0x06` acknowledges a key load. `0xEE` reports an 'E' command received while `key_valid` is 0.
- States: IDLE, RX_KEY, RX_PT, AES_RUN, TX_LOAD, TX_WAIT.
- IDLE:
  - 'K' goes to RX_KEY.
  - 'E' with `key_valid`=1 goes to RX_PT.
  - 'E' with `key_valid`=0 loads `0xEE` as a one-byte reply and goes to TX_LOAD.
- RX_KEY and RX_PT:
  - Each `rx_valid` shifts the byte into a 128-bit buffer: `buf <= {buf[119:0], rx_byte}`. The first byte received ends up in bits [127:120].
  - A 4-bit byte counter `byte_cnt` increments on each byte. It wraps 15→0 on the 16th byte.
- On the 16th byte in RX_KEY:
  - Commit `aes_key` from the buffer including the current byte.
  - Set `key_valid`.
  - Queue the one-byte reply `0x06` and go to TX_LOAD.
- On the 16th byte in RX_PT:
  - Load `aes_din` from the buffer including the current byte.
  - Go to AES_RUN.
- AES_RUN:
  - Pulse `aes_start` in the first cycle of the state only.
  - On `aes_done`, copy `aes_dout` into the tx buffer, set the reply length to 16, and go to TX_LOAD.
- TX_LOAD: drive `tx_data` with bits [127:120] of the tx buffer (or the status byte), pulse `tx_start`, and go to TX_WAIT.
- TX_WAIT: on `tx_done`, shift the tx buffer left by 8 and decrement the remaining count. Return to TX_LOAD while bytes remain; otherwise go to IDLE.
- Timeout:
  - The counter clears on any state change and on every `rx_valid`. It increments only in RX_KEY and RX_PT.
  - When it reaches `TIMEOUT_CYC-1`, go to IDLE and clear `byte_cnt`.
  - `aes_key`, `aes_din` and `key_valid` stay unchanged, so a partial key is never committed.
- `rx_valid` in AES_RUN, TX_LOAD or TX_WAIT is dropped with no effect.
- `aes_done` outside AES_RUN and `tx_done` outside TX_WAIT are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, buffers 0.
- Reset asserted mid-operation returns to IDLE on the next edge. A transfer already in flight in the transmitter or AES core is abandoned.
- `rx_valid` in cycle n updates state and buffers at edge n+1.
- `aes_start` is high in cycle n+1 after the 16th plaintext byte arrives in cycle n.
- `tx_start` is high in cycle n+2 after `aes_done` arrives in cycle n: one cycle for the capture edge into TX_LOAD, one for the pulse.
- `tx_start` for byte k+1 is high in cycle n+2 after byte k's `tx_done` arrives in cycle n.
- `tx_start` for a status byte is high in cycle n+2 after the command byte arrives in cycle n.
- `busy` rises one cycle after the accepted command byte. It falls one cycle after the final `tx_done`.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the last `rx_valid` or the state entry, with no byte arriving in between.

## Structure
- Shared package `aes_uart_pkg` holds:
  - the command codes `CMD_KEY`=8'h4B and `CMD_ENC`=8'h45;
  - the reply codes `RSP_ACK`=8'h06 and `RSP_NOKEY`=8'hEE;
  - the state enumeration;
  - `BLK_BYTES`=16.
- Sub-module `aes_uart_timeout` contains the idle counter, with inputs clear/enable and a one-cycle `expired` output.
- The FSM, shift buffers and byte counters stay in the top module.

## Test plan
- Send 'K' then bytes 0x00..0x0F with gaps of 50 cycles → `aes_key`=128'h000102030405060708090A0B0C0D0E0F, `key_valid`=1, one `tx_data`=0x06.
- From reset, send 'E' → single reply 0xEE, `aes_start` never asserted, `busy` low after `tx_done`.
- With a key loaded, send 'E' plus 16 plaintext bytes → `aes_start` pulses once, one cycle after the last byte. Model `aes_dout`=128'hAA55…AA55 returned 20 cycles later → 16 `tx_start`s carrying 0xAA,0x55,… in order, each issued 2 cycles after the previous `tx_done`.
- With `TIMEOUT_CYC`=100, send 'K' plus 5 bytes then stay idle → return to IDLE at cycle 100 after the 5th byte. `aes_key` and `key_valid` unchanged. A following 'E' is accepted as a command.
- During AES_RUN, inject `rx_valid` with 0x4B, and assert `aes_done` outside AES_RUN → no state change, buffers untouched.
- Assert `sys_rst_n`=0 for 1 cycle mid-ciphertext transmit → next cycle all outputs 0, `key_valid`=0, state IDLE.
